// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the byte-serial RAM/IO bus arbiter: FSM encodings,
// length width, word-size derivation and the IO window decode.
package ram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int LEN_W = 3;

  // IO space is selected by addr[17:16] == 2'b11; reserved for the IO decoder.
  localparam int         IO_ADDR_HI  = 17;
  localparam int         IO_ADDR_LO  = 16;
  localparam logic [1:0] IO_ADDR_SEL = 2'b11;

  function automatic int calc_max_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Zero or over-long lengths mean a full word.
  function automatic int clamp_len(input logic [LEN_W-1:0] len, input int max_bytes);
    if (len == '0 || int'(len) > max_bytes) return max_bytes;
    return int'(len);
  endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Read-channel picker: one-hot grant and index from a request vector,
// either fixed lowest-index priority or round-robin starting at ptr.
module ram_arbiter_pick #(
  parameter int NUM_RD      = 2,
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int IDX_W       = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic [NUM_RD-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_RD-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  // First pass searches ptr..NUM_RD-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    logic found;
    int   start;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    start = ROUND_ROBIN ? int'(ptr) : 0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!found && req[i] && i >= start) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NUM_RD read channels and one write channel onto the byte-serial
// RAM/IO bus. Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin read arbitration.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*LEN_W-1:0]  rd_len,
  input  logic [NUM_RD-1:0]        rd_signed,
  input  logic [NUM_RD-1:0]        rd_discard,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [LEN_W-1:0]         wr_len,
  output logic                     wr_busy,
  output logic                     wr_done,
  output logic                     ram_rw,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [7:0]               ram_w_data,
  input  logic [7:0]               ram_r_data
);

  localparam int MAX_BYTES = calc_max_bytes(DATA_W);
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int IDX_W     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          len;
  logic [ADDR_W-1:0]         base;
  logic [DATA_W-1:0]         wr_buf;
  logic [IDX_W-1:0]          ch;
  logic                      sgn;
  logic [MAX_BYTES-1:0][7:0] lanes;
  logic [DATA_W-1:0]         assembled;
  logic [NUM_RD-1:0]         ch_onehot;
  logic [NUM_RD-1:0]         pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic [IDX_W-1:0]          rr_ptr;
  logic [ADDR_W-1:0]         sel_addr;
  logic [LEN_W-1:0]          sel_len;
  logic                      sel_signed;
  logic                      cur_discard;
  logic                      read_last;

  assign read_last = (cnt == len);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (state == ST_READ && (cur_discard || read_last)) begin
      rr_ptr <= (int'(ch) == NUM_RD - 1) ? '0 : ch + IDX_W'(1);
    end
  end
`else
  localparam bit ROUND_ROBIN = 1'b0;
  assign rr_ptr = '0;
`endif

  ram_arbiter_pick #(
    .NUM_RD      (NUM_RD),
    .ROUND_ROBIN (ROUND_ROBIN),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req   (rd_req & ~rd_discard),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    ch_onehot   = '0;
    cur_discard = 1'b0;
    sel_addr    = '0;
    sel_len     = '0;
    sel_signed  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ch == IDX_W'(i)) begin
        ch_onehot[i] = 1'b1;
        cur_discard  = rd_discard[i];
      end
      if (pick_grant[i]) begin
        sel_addr   = rd_addr[i*ADDR_W +: ADDR_W];
        sel_len    = rd_len[i*LEN_W +: LEN_W];
        sel_signed = rd_signed[i];
      end
    end
  end

  // The final byte comes straight off the bus so rd_data is ready in cycle L.
  always_comb begin
    assembled = '0;
    for (int j = 0; j < MAX_BYTES; j++) begin
      if (CNT_W'(j + 1) < len)       assembled[j*8 +: 8] = lanes[j];
      else if (CNT_W'(j + 1) == len) assembled[j*8 +: 8] = ram_r_data;
      else                           assembled[j*8 +: 8] = {8{sgn & ram_r_data[7]}};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      len    <= '0;
      base   <= '0;
      wr_buf <= '0;
      ch     <= '0;
      sgn    <= 1'b0;
      lanes  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (wr_req) begin
            state  <= ST_WRITE;
            base   <= wr_addr;
            wr_buf <= wr_data;
            len    <= CNT_W'(clamp_len(wr_len, MAX_BYTES));
          end else if (|pick_grant) begin
            state <= ST_READ;
            ch    <= pick_idx;
            base  <= sel_addr;
            len   <= CNT_W'(clamp_len(sel_len, MAX_BYTES));
            sgn   <= sel_signed;
          end
        end
        ST_READ: begin
          if (cur_discard || read_last) begin
            state <= ST_IDLE;
          end else begin
            for (int j = 0; j < MAX_BYTES; j++) begin
              if (cnt == CNT_W'(j + 1)) lanes[j] <= ram_r_data;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (cnt == len - CNT_W'(1)) state <= ST_IDLE;
          else                        cnt   <= cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_busy    = '0;
    rd_ready   = '0;
    rd_data    = '0;
    wr_busy    = 1'b0;
    wr_done    = 1'b0;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    case (state)
      ST_READ: begin
        rd_busy = ch_onehot;
        if (!cur_discard) begin
          if (read_last) begin
            rd_ready = ch_onehot;
            rd_data  = assembled;
          end else begin
            ram_addr = base + ADDR_W'(cnt);
          end
        end
      end
      ST_WRITE: begin
        wr_busy    = 1'b1;
        ram_rw     = 1'b1;
        ram_addr   = base + ADDR_W'(cnt);
        ram_w_data = 8'(wr_buf >> {cnt, 3'b000});
        wr_done    = (cnt == len - CNT_W'(1));
      end
      default: ;
    endcase
  end

endmodule
